cordic_iter_engine: RTL and testbench

Parametrised iterative circular CORDIC engine, the next-generation arithmetic core behind the calculator top level. It supports rotation mode (sin/cos, polar-to-rectangular) and vectoring mode (magnitude/atan2, rectangular-to-polar) in one datapath. It adds full-circle angle reduction, optional gain compensation, output saturation with an overflow flag, and a start/busy/done handshake. All values are signed fixed point with FRAC fractional bits; the Q16.16 default matches the existing calculator.

---
 rtl/cordic_iter_engine.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_cordic_iter_engine.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cordic_iter_engine.sv
`default_nettype none
// ============================================================================
// Module      : cordic_iter_engine
// Description : Iterative circular CORDIC engine. One shared datapath serves
//               rotation mode (drive z to 0) and vectoring mode (drive y to
//               0), with full-circle angle reduction, optional 1/K gain
//               compensation, saturating outputs and a start/busy/done
//               handshake. Signed fixed point with FRAC fractional bits.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_iter_engine #(
  parameter int WIDTH      = 32,
  parameter int FRAC       = 16,
  parameter int ITERATIONS = 16,
  parameter int GAIN_COMP  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    mode,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic signed [WIDTH-1:0] z_in,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] y_out,
  output logic signed [WIDTH-1:0] z_out,
  output logic                    ovf
);

  // Two guard bits on x/y absorb the CORDIC gain plus the sqrt(2) growth of
  // a full-scale vector before saturation.
  localparam int XW    = WIDTH + 2;
  localparam int PW    = XW + WIDTH;
  localparam int CNT_W = $clog2(WIDTH);
  localparam int TAB_N = 1 << CNT_W;

  // Round-to-nearest right shift; a non-positive shift scales up instead.
  function automatic logic [63:0] round_shr(input logic [63:0] v, input int s);
    logic [63:0] r;
    if (s <= 0) r = v << (-s);
    else        r = (v + (64'd1 << (s - 1))) >> s;
    return r;
  endfunction

  // atan(2^-i) in Q2.30, rounded to nearest.
  function automatic logic [63:0] atan_q30(input int i);
    logic [63:0] r;
    case (i)
      0:       r = 64'd843314857;
      1:       r = 64'd497837829;
      2:       r = 64'd263043837;
      3:       r = 64'd133525159;
      4:       r = 64'd67021687;
      5:       r = 64'd33543516;
      6:       r = 64'd16775851;
      7:       r = 64'd8388437;
      8:       r = 64'd4194283;
      9:       r = 64'd2097149;
      10:      r = 64'd1048576;
      default: r = (i <= 30) ? (64'd1 << (30 - i)) : 64'd0;
    endcase
    return r;
  endfunction

  localparam logic [63:0] c_pi_q60   = 64'h3243F6A8885A308D;
  localparam logic [63:0] c_invk_q32 = 64'd2608131496;

  localparam logic signed [WIDTH-1:0] c_pi      = WIDTH'(round_shr(c_pi_q60, 60 - FRAC));
  localparam logic signed [WIDTH-1:0] c_half_pi = WIDTH'(round_shr(c_pi_q60, 61 - FRAC));
  localparam logic signed [WIDTH-1:0] c_two_pi  = WIDTH'(round_shr(c_pi_q60, 59 - FRAC));
  localparam logic signed [PW-1:0]    c_invk    = PW'(round_shr(c_invk_q32, 32 - FRAC));

  localparam logic signed [XW-1:0] c_sat_max = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] c_sat_min = {3'b111, {(WIDTH-1){1'b0}}};

  localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(ITERATIONS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_ITER = 2'd2,
    S_COMP = 2'd3
  } state_t;

  state_t                   r_state, w_state_next;
  logic [CNT_W-1:0]         r_iter, w_iter_next;
  logic                     w_finish;
  logic                     r_mode;
  logic signed [XW-1:0]     r_x, r_y;
  logic signed [WIDTH-1:0]  r_z;

  logic signed [WIDTH-1:0]  w_atan_tab [TAB_N];
  logic signed [WIDTH-1:0]  w_atan;

  logic signed [XW-1:0]     w_pre_x, w_pre_y;
  logic signed [WIDTH-1:0]  w_pre_z, w_red_z;
  logic                     w_d_pos;
  logic signed [XW-1:0]     w_x_sh, w_y_sh, w_x_next, w_y_next;
  logic signed [WIDTH-1:0]  w_z_next;
  logic signed [XW-1:0]     w_x_comp, w_y_comp;
  logic signed [XW-1:0]     w_x_res, w_y_res;
  logic signed [WIDTH-1:0]  w_z_res;
  logic signed [WIDTH-1:0]  w_x_sat, w_y_sat;
  logic                     w_x_clip, w_y_clip;

  logic                     r_done, r_ovf;
  logic signed [WIDTH-1:0]  r_x_out, r_y_out, r_z_out;

  // Arctangent table scaled from Q2.30 to Q(FRAC).
  for (genvar gi = 0; gi < TAB_N; gi++) begin : g_atan
    localparam logic signed [WIDTH-1:0] c_atan = WIDTH'(round_shr(atan_q30(gi), 30 - FRAC));
    assign w_atan_tab[gi] = c_atan;
  end

  assign w_atan = w_atan_tab[r_iter];

  // State and iteration counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_iter  <= '0;
    end else begin
      r_state <= w_state_next;
      r_iter  <= w_iter_next;
    end
  end

  // Next-state logic; w_finish marks the edge that loads the results.
  always_comb begin
    w_state_next = r_state;
    w_iter_next  = r_iter;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_next = S_PRE;
      S_PRE: begin
        w_state_next = S_ITER;
        w_iter_next  = '0;
      end
      S_ITER: begin
        if (r_iter == c_last_iter) begin
          if (GAIN_COMP != 0) begin
            w_state_next = S_COMP;
          end else begin
            w_state_next = S_IDLE;
            w_finish     = 1'b1;
          end
        end else begin
          w_iter_next = r_iter + 1'b1;
        end
      end
      S_COMP: begin
        w_state_next = S_IDLE;
        w_finish     = 1'b1;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign busy = (r_state != S_IDLE);

  // Quadrant pre-processing: bring the angle (rotation) or vector
  // (vectoring) into the right half-plane where the iterations converge.
  always_comb begin
    w_pre_x = r_x;
    w_pre_y = r_y;
    w_pre_z = r_z;
    w_red_z = r_z;
    if (r_mode) begin
      if (r_x[XW-1]) begin
        w_pre_x = -r_x;
        w_pre_y = -r_y;
        w_pre_z = r_y[XW-1] ? (r_z - c_pi) : (r_z + c_pi);
      end
    end else begin
      if (r_z > c_pi)       w_red_z = r_z - c_two_pi;
      else if (r_z < -c_pi) w_red_z = r_z + c_two_pi;
      w_pre_z = w_red_z;
      if (w_red_z > c_half_pi) begin
        w_pre_x = -r_x;
        w_pre_y = -r_y;
        w_pre_z = w_red_z - c_pi;
      end else if (w_red_z < -c_half_pi) begin
        w_pre_x = -r_x;
        w_pre_y = -r_y;
        w_pre_z = w_red_z + c_pi;
      end
    end
  end

  // One micro-rotation; x and y both use pre-step values.
  always_comb begin
    w_d_pos = r_mode ? r_y[XW-1] : ~r_z[WIDTH-1];
    w_x_sh  = r_x >>> r_iter;
    w_y_sh  = r_y >>> r_iter;
    if (w_d_pos) begin
      w_x_next = r_x - w_y_sh;
      w_y_next = r_y + w_x_sh;
      w_z_next = r_z - w_atan;
    end else begin
      w_x_next = r_x + w_y_sh;
      w_y_next = r_y - w_x_sh;
      w_z_next = r_z + w_atan;
    end
  end

  // Gain compensation: full-width product, floor shift back to Q(FRAC).
  always_comb begin
    w_x_comp = XW'((PW'(r_x) * c_invk) >>> FRAC);
    w_y_comp = XW'((PW'(r_y) * c_invk) >>> FRAC);
  end

  // Result selection and saturation to the WIDTH-bit output range.
  always_comb begin
    w_x_res  = (r_state == S_COMP) ? w_x_comp : w_x_next;
    w_y_res  = (r_state == S_COMP) ? w_y_comp : w_y_next;
    w_z_res  = (r_state == S_COMP) ? r_z : w_z_next;
    w_x_sat  = w_x_res[WIDTH-1:0];
    w_y_sat  = w_y_res[WIDTH-1:0];
    w_x_clip = 1'b0;
    w_y_clip = 1'b0;
    if (w_x_res > c_sat_max) begin
      w_x_sat  = {1'b0, {(WIDTH-1){1'b1}}};
      w_x_clip = 1'b1;
    end else if (w_x_res < c_sat_min) begin
      w_x_sat  = {1'b1, {(WIDTH-1){1'b0}}};
      w_x_clip = 1'b1;
    end
    if (w_y_res > c_sat_max) begin
      w_y_sat  = {1'b0, {(WIDTH-1){1'b1}}};
      w_y_clip = 1'b1;
    end else if (w_y_res < c_sat_min) begin
      w_y_sat  = {1'b1, {(WIDTH-1){1'b0}}};
      w_y_clip = 1'b1;
    end
  end

  // Working registers: capture, pre-process, iterate, compensate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode <= 1'b0;
      r_x    <= '0;
      r_y    <= '0;
      r_z    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode <= mode;
            r_x    <= XW'(x_in);
            r_y    <= XW'(y_in);
            r_z    <= z_in;
          end
        end
        S_PRE: begin
          r_x <= w_pre_x;
          r_y <= w_pre_y;
          r_z <= w_pre_z;
        end
        S_ITER: begin
          r_x <= w_x_next;
          r_y <= w_y_next;
          r_z <= w_z_next;
        end
        S_COMP: begin
          r_x <= w_x_comp;
          r_y <= w_y_comp;
        end
        default: ;
      endcase
    end
  end

  // Result registers and one-cycle done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_x_out <= '0;
      r_y_out <= '0;
      r_z_out <= '0;
    end else begin
      r_done <= w_finish;
      if (w_finish) begin
        r_x_out <= w_x_sat;
        r_y_out <= w_y_sat;
        r_z_out <= w_z_res;
        r_ovf   <= w_x_clip | w_y_clip;
      end
    end
  end

  assign done  = r_done;
  assign ovf   = r_ovf;
  assign x_out = r_x_out;
  assign y_out = r_y_out;
  assign z_out = r_z_out;

endmodule
`default_nettype wire

// File: tb/tb_cordic_iter_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_iter_engine
// Description : Directed self-checking bench for cordic_iter_engine, one
//               instance without and one with gain compensation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_iter_engine;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  logic mode = 1'b0;
  logic signed [W-1:0] x_in = '0;
  logic signed [W-1:0] y_in = '0;
  logic signed [W-1:0] z_in = '0;

  logic busy0, done0, ovf0, busy1, done1, ovf1;
  logic signed [W-1:0] xo0, yo0, zo0, xo1, yo1, zo1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cordic_iter_engine #(.WIDTH(32), .FRAC(16), .ITERATIONS(16), .GAIN_COMP(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .mode(mode),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .busy(busy0), .done(done0),
    .x_out(xo0), .y_out(yo0), .z_out(zo0), .ovf(ovf0)
  );

  cordic_iter_engine #(.WIDTH(32), .FRAC(16), .ITERATIONS(16), .GAIN_COMP(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .busy(busy1), .done(done1),
    .x_out(xo1), .y_out(yo1), .z_out(zo1), .ovf(ovf1)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_tol(input string tag, input longint obs, input longint exp,
                           input longint tol);
    logic ok;
    checks++;
    ok = ((obs - exp) <= tol) && ((exp - obs) <= tol);
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
    end
  endtask

  // Present operands and raise start on a falling edge.
  task automatic issue(input int sel, input logic m, input int x, input int y, input int z);
    @(negedge clk);
    mode = m;
    x_in = x;
    y_in = y;
    z_in = z;
    if (sel == 0) start0 = 1'b1;
    else          start1 = 1'b1;
  endtask

  // Count falling edges until done; lat = edges after the start-sampling
  // edge. Optionally injects a start pulse with junk operands at inject_at.
  task automatic wait_done(input int sel, input int inject_at, output int lat,
                           output logic b_first, output logic b_done);
    lat     = -1;
    b_first = 1'b0;
    b_done  = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
      if (c == 1) b_first = (sel == 0) ? busy0 : busy1;
      if (c == inject_at) begin
        mode = 1'b1;
        x_in = -32'sd65536;
        y_in = 32'sd12345;
        z_in = 32'sd999;
        if (sel == 0) start0 = 1'b1;
        else          start1 = 1'b1;
      end
      if (((sel == 0) ? done0 : done1) === 1'b1) begin
        lat    = c - 1;
        b_done = (sel == 0) ? busy0 : busy1;
        break;
      end
    end
  endtask

  initial begin
    int   lat;
    logic bf, bd;
    int   ndone;

    // Reset state
    #1 rst = 1'b0;
    #20;
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_ovf", ovf0, 0);
    check("rst_x", xo0, 0);
    check("rst_y", yo0, 0);
    check("rst_z", zo0, 0);
    @(negedge clk);
    rst = 1'b1;

    // Rotation pi/6 with 1/K input amplitude
    issue(0, 1'b0, 39797, 0, 34315);
    wait_done(0, 0, lat, bf, bd);
    check("rot30_lat", lat, 17);
    check("rot30_busy_rise", bf, 1);
    check("rot30_busy_fall", bd, 0);
    check_tol("rot30_x", xo0, 56756, 8);
    check_tol("rot30_y", yo0, 32768, 8);
    check_tol("rot30_z", zo0, 0, 4);
    check("rot30_ovf", ovf0, 0);
    @(negedge clk);
    check("rot30_done_pulse", done0, 0);

    // Rotation 200 and -200 degrees (full-circle reduction)
    issue(0, 1'b0, 39797, 0, 228764);
    wait_done(0, 0, lat, bf, bd);
    check_tol("rot200_x", xo0, -61584, 8);
    check_tol("rot200_y", yo0, -22415, 8);
    issue(0, 1'b0, 39797, 0, -228764);
    wait_done(0, 0, lat, bf, bd);
    check_tol("rotm200_x", xo0, -61584, 8);
    check_tol("rotm200_y", yo0, 22415, 8);

    // Vectoring (3,4) with gain compensation
    issue(1, 1'b1, 196608, 262144, 0);
    wait_done(1, 0, lat, bf, bd);
    check("vec34_lat", lat, 18);
    check_tol("vec34_x", xo1, 327680, 16);
    check_tol("vec34_y", yo1, 0, 16);
    check_tol("vec34_z", zo1, 60771, 8);
    check("vec34_ovf", ovf1, 0);

    // Vectoring overflow
    issue(0, 1'b1, 32'h7FFF0000, 32'h7FFF0000, 0);
    wait_done(0, 0, lat, bf, bd);
    check("ovf_x", xo0, 32'sh7FFFFFFF);
    check("ovf_flag", ovf0, 1);
    check_tol("ovf_z", zo0, 51472, 8);

    // Vectoring negative x on the real axis
    issue(0, 1'b1, -65536, 0, 0);
    wait_done(0, 0, lat, bf, bd);
    check_tol("vecneg_x", xo0, 107922, 16);
    check_tol("vecneg_z", zo0, 205887, 8);
    check("vecneg_ovf", ovf0, 0);

    // Start during busy is ignored
    issue(0, 1'b0, 39797, 0, 34315);
    wait_done(0, 5, lat, bf, bd);
    check("ign_lat", lat, 17);
    check_tol("ign_x", xo0, 56756, 8);
    check_tol("ign_y", yo0, 32768, 8);

    // Back-to-back start in the done cycle
    mode   = 1'b1;
    x_in   = -65536;
    y_in   = 0;
    z_in   = 0;
    start0 = 1'b1;
    wait_done(0, 0, lat, bf, bd);
    check("b2b_gap", lat + 1, 18);
    check_tol("b2b_x", xo0, 107922, 16);

    // Reset in the middle of iteration 5
    issue(0, 1'b0, 39797, 0, 34315);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      start0 = 1'b0;
    end
    #2 rst = 1'b0;
    #1;
    check("abort_busy", busy0, 0);
    check("abort_done", done0, 0);
    check("abort_x", xo0, 0);
    check("abort_y", yo0, 0);
    check("abort_z", zo0, 0);
    @(negedge clk);
    rst   = 1'b1;
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done0 === 1'b1) ndone++;
    end
    check("abort_no_done", ndone, 0);
    check("abort_idle", busy0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
